// File: rtl/cla16_sub_pipe.sv
// rtl/cla16_sub_pipe.sv - two-stage 16-bit carry-lookahead subtractor with valid/ready handshake
//
// Computes a - b - bin as a + ~b + ~bin using 4-bit lookahead groups and a
// second-level lookahead across the groups.
//   clk       : clock, all state on rising edge
//   rst_n     : asynchronous active-low reset
//   in_valid  : a/b/bin valid          in_ready  : operands accepted this cycle
//   a, b, bin : minuend, subtrahend, borrow-in
//   out_valid : result valid           out_ready : consumer takes result
//   diff      : (a - b - bin) mod 2^16
//   bout      : unsigned borrow-out    ovf : signed overflow    zero : diff == 0
module cla16_sub_pipe (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        bin,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] diff,
  output logic        bout,
  output logic        ovf,
  output logic        zero
);

  // Carries into bit positions 0..3 of one group; c[0] is the group carry-in.
  function automatic logic [3:0] grp_carries(input logic [3:0] p, input logic [3:0] g,
                                             input logic cin);
    logic [3:0] c;
    c[0] = cin;
    c[1] = g[0] | (p[0] & cin);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    return c;
  endfunction

  // Stage 1 registers
  logic        s1_valid;
  logic [15:0] s1_p, s1_g;
  logic        s1_c0, s1_c4, s1_c8, s1_c12, s1_c16;
  logic        s1_a15, s1_b15;

  // Handshake
  logic s2_adv, s1_adv;
  assign s2_adv   = !out_valid || out_ready;
  assign s1_adv   = !s1_valid || s2_adv;
  assign in_ready = s1_adv;

  // Stage 1 combinational: bit and group propagate/generate, boundary carries
  logic [15:0] p_in, g_in;
  logic [3:0]  gp, gg;
  logic        c0_in, c4_in, c8_in, c12_in, c16_in;

  always_comb begin
    p_in  = a ^ ~b;
    g_in  = a & ~b;
    c0_in = ~bin;
    for (int k = 0; k < 4; k++) begin
      gp[k] = &p_in[4*k +: 4];
      gg[k] = g_in[4*k+3]
            | (p_in[4*k+3] & g_in[4*k+2])
            | (p_in[4*k+3] & p_in[4*k+2] & g_in[4*k+1])
            | (p_in[4*k+3] & p_in[4*k+2] & p_in[4*k+1] & g_in[4*k]);
    end
    // Each boundary carry is a flat sum of products; nothing ripples group to group.
    c4_in  = gg[0] | (gp[0] & c0_in);
    c8_in  = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & c0_in);
    c12_in = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
           | (gp[2] & gp[1] & gp[0] & c0_in);
    c16_in = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
           | (gp[3] & gp[2] & gp[1] & gg[0]) | (gp[3] & gp[2] & gp[1] & gp[0] & c0_in);
  end

  // Stage 2 combinational: intra-group carries seeded by the boundary carries
  logic [3:0]  s2_cin;
  logic [15:0] s2_c, s2_diff;

  always_comb begin
    s2_cin = {s1_c12, s1_c8, s1_c4, s1_c0};
    for (int k = 0; k < 4; k++) begin
      s2_c[4*k +: 4] = grp_carries(s1_p[4*k +: 4], s1_g[4*k +: 4], s2_cin[k]);
    end
    s2_diff = s1_p ^ s2_c;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_p      <= '0;
      s1_g      <= '0;
      s1_c0     <= 1'b0;
      s1_c4     <= 1'b0;
      s1_c8     <= 1'b0;
      s1_c12    <= 1'b0;
      s1_c16    <= 1'b0;
      s1_a15    <= 1'b0;
      s1_b15    <= 1'b0;
      out_valid <= 1'b0;
      diff      <= '0;
      bout      <= 1'b0;
      ovf       <= 1'b0;
      zero      <= 1'b0;
    end else begin
      if (s2_adv) begin
        out_valid <= s1_valid;
        if (s1_valid) begin
          diff <= s2_diff;
          bout <= ~s1_c16;
          ovf  <= (s1_a15 != s1_b15) && (s2_diff[15] != s1_a15);
          zero <= (s2_diff == 16'h0000);
        end
      end
      if (s1_adv) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_p   <= p_in;
          s1_g   <= g_in;
          s1_c0  <= c0_in;
          s1_c4  <= c4_in;
          s1_c8  <= c8_in;
          s1_c12 <= c12_in;
          s1_c16 <= c16_in;
          s1_a15 <= a[15];
          s1_b15 <= b[15];
        end
      end
    end
  end

endmodule
